// File: rtl/zap_fetch_main.sv
// Fetch pipeline register: latches word/PC/PC+8/abort and attaches a 2-bit branch prediction.
// Optional predictor table and init FSM enabled by ZAP_BRANCH_PREDICTOR_EN; latency 1, stalls hold, clears flush.
module zap_fetch_main #(
    parameter int BP_ENTRIES = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_code_stall,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_clear_from_alu,
    input  logic        i_stall_from_shifter,
    input  logic        i_stall_from_issue,
    input  logic        i_stall_from_decode,
    input  logic        i_clear_from_decode,
    input  logic        i_cpu_mode_t,
    input  logic [31:0] i_pc_ff,
    input  logic [31:0] i_instruction,
    input  logic        i_valid,
    input  logic        i_instr_abort,
    input  logic        i_bp_upd_valid,
    input  logic [31:0] i_bp_upd_pc,
    input  logic        i_bp_upd_taken,
    output logic [31:0] o_instruction,
    output logic        o_valid,
    output logic        o_instr_abort,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [1:0]  o_taken,
    output logic        o_bp_init
);
    localparam logic [1:0] WNT = 2'b01;

    logic        valid_q, valid_d;
    logic        abort_q, abort_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc8_q, pc8_d;
    logic [1:0]  taken_q, taken_d;
    logic [1:0]  pred;
    logic        init_busy;
    logic        unused_bp;

`ifdef ZAP_BRANCH_PREDICTOR_EN
    localparam int IDX_W = $clog2(BP_ENTRIES);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [1:0]       bp_q [BP_ENTRIES];
    logic [IDX_W-1:0] rd_idx, upd_idx, wr_idx;
    logic [1:0]       upd_old, upd_new, wr_dat;
    logic             wr_en;

    assign rd_idx    = i_pc_ff[IDX_W:1];
    assign upd_idx   = i_bp_upd_pc[IDX_W:1];
    assign upd_old   = bp_q[upd_idx];
    assign unused_bp = ^{i_bp_upd_pc[31:IDX_W+1], i_bp_upd_pc[0]};

    always_comb begin
        upd_new = upd_old;
        if (i_bp_upd_taken && upd_old != 2'b11) begin
            upd_new = upd_old + 2'd1;
        end else if (!i_bp_upd_taken && upd_old != 2'b00) begin
            upd_new = upd_old - 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The init walk advances every cycle regardless of stalls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(BP_ENTRIES - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    always_comb begin
        init_busy = (state_q == S_INIT);
        wr_en     = 1'b0;
        wr_idx    = cnt_q;
        wr_dat    = WNT;
        if (!i_reset) begin
            if (state_q == S_INIT) begin
                wr_en = 1'b1;
            end else if (i_bp_upd_valid) begin
                wr_en  = 1'b1;
                wr_idx = upd_idx;
                wr_dat = upd_new;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            bp_q[wr_idx] <= wr_dat;
        end
    end

    // Read is old-value on a same-cycle write to the same entry.
    assign pred      = bp_q[rd_idx];
    assign o_bp_init = init_busy;
`else
    assign pred      = WNT;
    assign init_busy = 1'b0;
    assign o_bp_init = 1'b0;
    assign unused_bp = ^{i_bp_upd_valid, i_bp_upd_pc, i_bp_upd_taken};
`endif

    always_comb begin
        valid_d = valid_q;
        abort_d = abort_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        taken_d = taken_q;
        if (init_busy || (!i_code_stall && (i_clear_from_writeback ||
            (!i_data_stall && (i_clear_from_alu ||
            (!i_stall_from_shifter && !i_stall_from_issue && !i_stall_from_decode &&
             i_clear_from_decode)))))) begin
            valid_d = 1'b0;
            abort_d = 1'b0;
            instr_d = '0;
            pc_d    = '0;
            pc8_d   = '0;
            taken_d = WNT;
        end else if (!i_code_stall && !i_data_stall && !i_stall_from_shifter &&
                     !i_stall_from_issue && !i_stall_from_decode) begin
            valid_d = i_valid;
            abort_d = i_instr_abort & i_valid;
            instr_d = i_instruction;
            pc_d    = i_pc_ff;
            pc8_d   = i_pc_ff + (i_cpu_mode_t ? 32'd4 : 32'd8);
            taken_d = (i_instr_abort || !i_valid) ? WNT : pred;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            pc8_q   <= '0;
            taken_q <= WNT;
        end else begin
            valid_q <= valid_d;
            abort_q <= abort_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc8_q   <= pc8_d;
            taken_q <= taken_d;
        end
    end

    assign o_valid        = valid_q;
    assign o_instr_abort  = abort_q;
    assign o_instruction  = instr_q;
    assign o_pc_ff        = pc_q;
    assign o_pc_plus_8_ff = pc8_q;
    assign o_taken        = taken_q;

endmodule

// File: tb/tb_zap_fetch_main.sv
// Bench for zap_fetch_main with a 16-entry table: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the pipeline register and prediction table.
module tb_zap_fetch_main;
    localparam int N_BP = 16;
`ifdef ZAP_BRANCH_PREDICTOR_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    logic        clk;
    logic        i_reset, i_code_stall, i_clear_from_writeback, i_data_stall, i_clear_from_alu;
    logic        i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode, i_clear_from_decode;
    logic        i_cpu_mode_t, i_valid, i_instr_abort, i_bp_upd_valid, i_bp_upd_taken;
    logic [31:0] i_pc_ff, i_instruction, i_bp_upd_pc;
    logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
    logic        o_valid, o_instr_abort, o_bp_init;
    logic [1:0]  o_taken;
    logic [100:0] dut_vec;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int          tbl [N_BP];
    int          init_left = 0;
    logic        m_valid = 1'b0, m_abort = 1'b0;
    logic [1:0]  m_taken = 2'b01;
    logic [31:0] m_instr = '0, m_pc = '0, m_pc8 = '0;

    zap_fetch_main #(.BP_ENTRIES(N_BP)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_code_stall(i_code_stall),
        .i_clear_from_writeback(i_clear_from_writeback), .i_data_stall(i_data_stall),
        .i_clear_from_alu(i_clear_from_alu), .i_stall_from_shifter(i_stall_from_shifter),
        .i_stall_from_issue(i_stall_from_issue), .i_stall_from_decode(i_stall_from_decode),
        .i_clear_from_decode(i_clear_from_decode), .i_cpu_mode_t(i_cpu_mode_t),
        .i_pc_ff(i_pc_ff), .i_instruction(i_instruction), .i_valid(i_valid),
        .i_instr_abort(i_instr_abort), .i_bp_upd_valid(i_bp_upd_valid),
        .i_bp_upd_pc(i_bp_upd_pc), .i_bp_upd_taken(i_bp_upd_taken),
        .o_instruction(o_instruction), .o_valid(o_valid), .o_instr_abort(o_instr_abort),
        .o_pc_ff(o_pc_ff), .o_pc_plus_8_ff(o_pc_plus_8_ff), .o_taken(o_taken),
        .o_bp_init(o_bp_init)
    );

    assign dut_vec = {o_valid, o_instr_abort, o_taken, o_bp_init, o_instruction, o_pc_ff, o_pc_plus_8_ff};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [100:0] exp_vec();
        return {m_valid, m_abort, m_taken, (init_left > 0), m_instr, m_pc, m_pc8};
    endfunction

    function automatic logic [31:0] rand_pc();
        return ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 1);
    endfunction

    task automatic idle();
        i_reset = 0; i_code_stall = 0; i_clear_from_writeback = 0; i_data_stall = 0;
        i_clear_from_alu = 0; i_stall_from_shifter = 0; i_stall_from_issue = 0;
        i_stall_from_decode = 0; i_clear_from_decode = 0; i_cpu_mode_t = 0;
        i_valid = 0; i_instr_abort = 0; i_bp_upd_valid = 0; i_bp_upd_taken = 0;
        i_pc_ff = '0; i_instruction = '0; i_bp_upd_pc = '0;
    endtask

    // Advance one clock: update the model from the inputs presented now, then settle at negedge.
    task automatic tick();
        int   ri, ui, act;
        logic ctl [8];
        bit   is_clear [8];
        logic [1:0] old_pred;
        is_clear = '{0, 1, 0, 1, 0, 0, 0, 1};
        ctl = '{i_code_stall, i_clear_from_writeback, i_data_stall, i_clear_from_alu,
                i_stall_from_shifter, i_stall_from_issue, i_stall_from_decode, i_clear_from_decode};
        ri = int'((i_pc_ff >> 1) % 32'(N_BP));
        old_pred = 2'(tbl[ri]);
        if (i_reset) begin
            init_left = BP_EN ? N_BP : 0;
            act = 2;
        end else begin
            if (BP_EN && init_left == 0 && i_bp_upd_valid) begin
                ui = int'((i_bp_upd_pc >> 1) % 32'(N_BP));
                if (i_bp_upd_taken) tbl[ui] = (tbl[ui] < 3) ? tbl[ui] + 1 : 3;
                else                tbl[ui] = (tbl[ui] > 0) ? tbl[ui] - 1 : 0;
            end
            act = 0;
            for (int k = 0; k < 8; k++) begin
                if (ctl[k]) begin
                    act = is_clear[k] ? 2 : 1;
                    break;
                end
            end
            if (init_left > 0) begin
                act = 2;
                tbl[N_BP - init_left] = 1;
                init_left--;
            end
        end
        if (act == 2) begin
            m_valid = 0; m_abort = 0; m_taken = 2'b01; m_instr = '0; m_pc = '0; m_pc8 = '0;
        end else if (act == 0) begin
            m_valid = i_valid;
            m_abort = i_valid & i_instr_abort;
            m_instr = i_instruction;
            m_pc    = i_pc_ff;
            m_pc8   = i_pc_ff + (i_cpu_mode_t ? 32'd4 : 32'd8);
            m_taken = (!BP_EN || i_instr_abort || !i_valid) ? 2'b01 : old_pred;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cnt;
        idle();
        i_reset = 1; tick(); tick();
        n_checks++; if ({o_valid, o_instr_abort, o_taken} !== 4'b0001) begin n_fail++;
            $display("FAIL reset_ctl: got %b want 0001", {o_valid, o_instr_abort, o_taken}); end
        n_checks++; if ({o_pc_ff, o_instruction, o_pc_plus_8_ff} !== 96'h0) begin n_fail++;
            $display("FAIL reset_data: got %h want 0", {o_pc_ff, o_instruction, o_pc_plus_8_ff}); end
        n_checks++; if (o_bp_init !== BP_EN) begin n_fail++;
            $display("FAIL reset_bp_init: got %b want %b", o_bp_init, BP_EN); end
        i_reset = 0; i_valid = 1; i_pc_ff = 32'h80; i_instruction = 32'hE1A00000;
        cnt = 0;
        for (int k = 0; k < 64 && o_bp_init === 1'b1; k++) begin
            cnt++;
            n_checks++; if (o_valid !== 1'b0) begin n_fail++;
                $display("FAIL init_valid: got %b want 0 at init cycle %0d", o_valid, k); end
            tick();
        end
        n_checks++; if (cnt != (BP_EN ? N_BP : 0)) begin n_fail++;
            $display("FAIL init_len: got %0d want %0d", cnt, BP_EN ? N_BP : 0); end
        for (int e = 0; e < N_BP; e++) begin
            i_pc_ff = 32'(e) << 1; i_valid = 1;
            tick();
            n_checks++; if ({o_valid, o_taken} !== 3'b101) begin n_fail++;
                $display("FAIL init_entry_%0d: got %b want 101", e, {o_valid, o_taken}); end
        end
    endtask

    task automatic test_pc_plus_8();
        idle();
        i_valid = 1; i_pc_ff = 32'h100; i_instruction = 32'hEA000004; tick();
        n_checks++; if ({o_pc_plus_8_ff, o_instruction, o_taken} !== {32'h108, 32'hEA000004, 2'b01}) begin
            n_fail++; $display("FAIL pc8_arm: got %h/%h/%b want 108/ea000004/01",
                               o_pc_plus_8_ff, o_instruction, o_taken); end
        i_cpu_mode_t = 1; tick();
        n_checks++; if (o_pc_plus_8_ff !== 32'h104) begin n_fail++;
            $display("FAIL pc8_thumb: got %h want 104", o_pc_plus_8_ff); end
        i_cpu_mode_t = 0; i_pc_ff = 32'hFFFF_FFFC; tick();
        n_checks++; if (o_pc_plus_8_ff !== 32'h4) begin n_fail++;
            $display("FAIL pc8_wrap: got %h want 4", o_pc_plus_8_ff); end
    endtask

    task automatic test_bp_train();
        idle();
        i_bp_upd_valid = 1; i_bp_upd_pc = 32'h40; i_bp_upd_taken = 1;
        tick(); tick();
        i_bp_upd_valid = 0; i_valid = 1; i_pc_ff = 32'h40; tick();
        n_checks++; if (o_taken !== (BP_EN ? 2'b11 : 2'b01)) begin n_fail++;
            $display("FAIL train_st: got %b want %b", o_taken, BP_EN ? 2'b11 : 2'b01); end
        i_valid = 0; i_bp_upd_valid = 1; tick();
        i_bp_upd_valid = 0; i_valid = 1; tick();
        n_checks++; if (o_taken !== (BP_EN ? 2'b11 : 2'b01)) begin n_fail++;
            $display("FAIL train_sat: got %b want %b", o_taken, BP_EN ? 2'b11 : 2'b01); end
    endtask

    task automatic test_same_cycle();
        idle();
        i_bp_upd_valid = 1; i_bp_upd_pc = 32'h40; i_bp_upd_taken = 0;
        tick(); tick();
        i_bp_upd_taken = 1; i_valid = 1; i_pc_ff = 32'h40; tick();
        n_checks++; if (o_taken !== 2'b01) begin n_fail++;
            $display("FAIL same_cycle_old: got %b want 01", o_taken); end
        i_bp_upd_valid = 0; tick();
        n_checks++; if (o_taken !== (BP_EN ? 2'b10 : 2'b01)) begin n_fail++;
            $display("FAIL same_cycle_new: got %b want %b", o_taken, BP_EN ? 2'b10 : 2'b01); end
    endtask

    task automatic test_stall_clear();
        idle();
        i_valid = 1; i_pc_ff = 32'h200; i_instruction = 32'h12345678; tick();
        i_code_stall = 1; i_clear_from_writeback = 1; i_pc_ff = 32'h300; i_instruction = 32'h0;
        tick();
        n_checks++; if ({o_valid, o_pc_ff, o_instruction} !== {1'b1, 32'h200, 32'h12345678}) begin
            n_fail++; $display("FAIL code_stall_hold: got %b/%h/%h want 1/200/12345678",
                               o_valid, o_pc_ff, o_instruction); end
        i_code_stall = 0; i_clear_from_writeback = 0; i_clear_from_alu = 1; i_stall_from_issue = 1;
        tick();
        n_checks++; if ({o_valid, o_taken} !== 3'b001) begin n_fail++;
            $display("FAIL alu_clear_under_issue: got %b want 001", {o_valid, o_taken}); end
        idle(); i_valid = 1; i_pc_ff = 32'h204; tick();
        i_stall_from_decode = 1; i_clear_from_decode = 1; i_pc_ff = 32'h208; tick();
        n_checks++; if ({o_valid, o_pc_ff} !== {1'b1, 32'h204}) begin n_fail++;
            $display("FAIL decode_stall_over_clear: got %b/%h want 1/204", o_valid, o_pc_ff); end
        i_stall_from_decode = 0; tick();
        n_checks++; if (o_valid !== 1'b0) begin n_fail++;
            $display("FAIL decode_clear: got %b want 0", o_valid); end
        i_clear_from_decode = 0; i_data_stall = 1; tick();
        n_checks++; if (dut_vec !== exp_vec()) begin n_fail++;
            $display("FAIL data_stall_hold: got %h want %h", dut_vec, exp_vec()); end
    endtask

    task automatic test_abort();
        idle();
        i_bp_upd_valid = 1; i_bp_upd_pc = 32'h46; i_bp_upd_taken = 1; tick(); tick();
        i_bp_upd_valid = 0; i_valid = 1; i_instr_abort = 1; i_pc_ff = 32'h46; tick();
        n_checks++; if ({o_valid, o_instr_abort, o_taken} !== 4'b1101) begin n_fail++;
            $display("FAIL abort_pred: got %b want 1101", {o_valid, o_instr_abort, o_taken}); end
        i_instr_abort = 0; tick();
        n_checks++; if ({o_instr_abort, o_taken} !== {1'b0, BP_EN ? 2'b11 : 2'b01}) begin n_fail++;
            $display("FAIL noabort_pred: got %b want %b", {o_instr_abort, o_taken},
                     {1'b0, BP_EN ? 2'b11 : 2'b01}); end
        i_instr_abort = 1; i_valid = 0; tick();
        n_checks++; if ({o_valid, o_instr_abort, o_taken} !== 4'b0001) begin n_fail++;
            $display("FAIL abort_invalid: got %b want 0001", {o_valid, o_instr_abort, o_taken}); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            i_reset                = ($urandom_range(0, 199) == 0);
            i_code_stall           = ($urandom_range(0, 9) == 0);
            i_clear_from_writeback = ($urandom_range(0, 11) == 0);
            i_data_stall           = ($urandom_range(0, 9) == 0);
            i_clear_from_alu       = ($urandom_range(0, 11) == 0);
            i_stall_from_shifter   = ($urandom_range(0, 9) == 0);
            i_stall_from_issue     = ($urandom_range(0, 9) == 0);
            i_stall_from_decode    = ($urandom_range(0, 9) == 0);
            i_clear_from_decode    = ($urandom_range(0, 11) == 0);
            i_cpu_mode_t           = 1'($urandom_range(0, 1));
            i_pc_ff                = rand_pc();
            i_instruction          = $urandom;
            i_valid                = ($urandom_range(0, 3) != 0);
            i_instr_abort          = ($urandom_range(0, 7) == 0);
            i_bp_upd_valid         = 1'($urandom_range(0, 1));
            i_bp_upd_pc            = rand_pc();
            i_bp_upd_taken         = ($urandom_range(0, 2) != 0);
            tick();
            n_checks++; if (dut_vec !== exp_vec()) begin n_fail++;
                $display("FAIL random_c%0d: got %h want %h", c, dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        for (int e = 0; e < N_BP; e++) tbl[e] = 1;
        idle();
        test_reset();
        test_pc_plus_8();
        test_bp_train();
        test_same_cycle();
        test_stall_clear();
        test_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
